// File: rtl/snoop_bus_responder.sv
// ---------------------------------------------------------------------------
// snoop_bus_responder
//
// Shared-bus side of the LLC bus protocol. Accepts one bus operation from a
// requesting LLC, broadcasts it to every other agent, collects and combines
// the snoop results, waits for the HITM owner's writeback when the operation
// needs the data, and returns the combined result. One transaction in flight.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The request side holds req_* stable while req_valid is high; the response
// side holds rsp_result/rsp_err stable while rsp_valid is high and not yet
// accepted. Neither ready depends combinationally on the matching valid.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (req_ready = FSM in IDLE)
//   req_op                READ=1 WRITE=2 INVALIDATE=3 RWIM=4
//   req_addr, req_id      line address, requesting agent (never snooped)
//   snp_valid             one-cycle snoop strobe per agent
//   snp_op, snp_addr      broadcast op/address, held until next accept
//   snp_rsp_valid         per-agent snoop response strobe
//   snp_rsp               per-agent result, 2 bits each: HIT=00 HITM=01 NOHIT=10
//   wb_done               per-agent writeback-complete strobe
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            HIT=00 HITM=01 NOHIT=10 NORESULT=11
//   rsp_err               protocol error or timeout in this transaction
//   dbg_state             FSM state: 0 IDLE, 1 SNOOP, 2 WAIT_WB, 3 RESP
//
// Optional feature macro: SNOOP_BUS_STATS_EN
//   When defined, adds saturating 32-bit counters stat_txn (response
//   handshakes), stat_hitm (HITM results handed over) and stat_timeout
//   (SNOOP or WAIT_WB timeouts). When undefined these ports do not exist.
// ---------------------------------------------------------------------------
module snoop_bus_responder #(
  parameter int NUM_AGENTS    = 4,
  parameter int SNOOP_TIMEOUT = 8,
  parameter int WB_TIMEOUT    = 16,
  localparam int AW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [31:0]             req_addr,
  input  logic [AW-1:0]           req_id,
  output logic [NUM_AGENTS-1:0]   snp_valid,
  output logic [2:0]              snp_op,
  output logic [31:0]             snp_addr,
  input  logic [NUM_AGENTS-1:0]   snp_rsp_valid,
  input  logic [2*NUM_AGENTS-1:0] snp_rsp,
  input  logic [NUM_AGENTS-1:0]   wb_done,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_result,
  output logic                    rsp_err,
  output logic [1:0]              dbg_state
`ifdef SNOOP_BUS_STATS_EN
  ,
  output logic [31:0]             stat_txn,
  output logic [31:0]             stat_hitm,
  output logic [31:0]             stat_timeout
`endif
);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] RES_HIT      = 2'b00;
  localparam logic [1:0] RES_HITM     = 2'b01;
  localparam logic [1:0] RES_NOHIT    = 2'b10;
  localparam logic [1:0] RES_NORESULT = 2'b11;

  localparam int TMAX = (SNOOP_TIMEOUT > WB_TIMEOUT) ? SNOOP_TIMEOUT : WB_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SNOOP   = 2'd1,
    S_WAIT_WB = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                  state_q, state_n;
  logic [2:0]              op_q, op_n;
  logic [31:0]             addr_q, addr_n;
  logic [AW-1:0]           id_q, id_n;
  logic [NUM_AGENTS-1:0]   pend_q, pend_n;
  logic [NUM_AGENTS-1:0]   hit_q, hit_n;
  logic [NUM_AGENTS-1:0]   hitm_q, hitm_n;
  logic [NUM_AGENTS-1:0]   snpv_q, snpv_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [AW-1:0]           owner_q, owner_n;
  logic [1:0]              result_q, result_n;
  logic                    err_q, err_n;
  logic                    snoop_to, wb_to;

  logic [NUM_AGENTS-1:0]   req_mask;
  logic [NUM_AGENTS-1:0]   accepted;
  logic [NUM_AGENTS-1:0]   acc_hit, acc_hitm;
  logic [NUM_AGENTS-1:0]   hit_all, hitm_all, pend_left;
  logic [AW-1:0]           owner_c;
  logic                    multi_hitm;

  // Everyone except the requester is snooped.
  assign req_mask = ~(NUM_AGENTS'(1) << req_id);

  // Only strobes from agents still pending are logged; this drops strobes
  // from the requester, from agents that already answered, and stray ones.
  assign accepted  = snp_rsp_valid & pend_q;
  assign pend_left = pend_q & ~accepted;
  assign hit_all   = hit_q | acc_hit;
  assign hitm_all  = hitm_q | acc_hitm;
  assign multi_hitm = |(hitm_all & (hitm_all - NUM_AGENTS'(1)));

  always_comb begin
    acc_hit  = '0;
    acc_hitm = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      acc_hit[i]  = accepted[i] && (snp_rsp[2*i +: 2] == RES_HIT);
      acc_hitm[i] = accepted[i] && (snp_rsp[2*i +: 2] == RES_HITM);
    end
  end

  // Lowest-index HITM agent owns the line.
  always_comb begin
    owner_c = '0;
    for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
      if (hitm_all[i]) owner_c = AW'(i);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_n  = state_q;
    op_n     = op_q;
    addr_n   = addr_q;
    id_n     = id_q;
    pend_n   = pend_q;
    hit_n    = hit_q;
    hitm_n   = hitm_q;
    snpv_n   = '0;
    cnt_n    = cnt_q;
    owner_n  = owner_q;
    result_n = result_q;
    err_n    = err_q;
    snoop_to = 1'b0;
    wb_to    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_n     = req_op;
          addr_n   = req_addr;
          id_n     = req_id;
          hit_n    = '0;
          hitm_n   = '0;
          cnt_n    = '0;
          owner_n  = '0;
          err_n    = 1'b0;
          result_n = RES_NORESULT;
          if (req_op == OP_READ || req_op == OP_INV || req_op == OP_RWIM) begin
            state_n = S_SNOOP;
            pend_n  = req_mask;
            snpv_n  = req_mask;
          end else begin
            // WRITE needs no snoop; anything outside the op set is an error.
            state_n = S_RESP;
            pend_n  = '0;
            err_n   = (req_op != OP_WRITE);
          end
        end
      end

      S_SNOOP: begin
        pend_n = pend_left;
        hit_n  = hit_all;
        hitm_n = hitm_all;
        cnt_n  = cnt_q + CW'(1);
        // cnt_q counts snoop cycles already completed, so the decision at
        // cnt_q == SNOOP_TIMEOUT still includes responses arriving now.
        if (pend_left == '0 || cnt_q == CW'(SNOOP_TIMEOUT)) begin
          snoop_to = (pend_left != '0);
          pend_n   = '0;
          owner_n  = owner_c;
          if (snoop_to || multi_hitm) err_n = 1'b1;
          if (hitm_all != '0)      result_n = RES_HITM;
          else if (hit_all != '0)  result_n = RES_HIT;
          else                     result_n = RES_NOHIT;
          if (hitm_all != '0 && op_q != OP_INV) begin
            state_n = S_WAIT_WB;
            cnt_n   = CW'(1);
          end else begin
            // An INVALIDATE that finds a modified copy is a protocol error;
            // the data is discarded rather than written back.
            if (hitm_all != '0) err_n = 1'b1;
            state_n = S_RESP;
          end
        end
      end

      S_WAIT_WB: begin
        if (wb_done[owner_q]) begin
          state_n = S_RESP;
        end else if (cnt_q == CW'(WB_TIMEOUT)) begin
          state_n = S_RESP;
          err_n   = 1'b1;
          wb_to   = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_n  = S_IDLE;
          err_n    = 1'b0;
          result_n = RES_NORESULT;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      pend_q   <= '0;
      hit_q    <= '0;
      hitm_q   <= '0;
      snpv_q   <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      result_q <= RES_NORESULT;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      op_q     <= op_n;
      addr_q   <= addr_n;
      id_q     <= id_n;
      pend_q   <= pend_n;
      hit_q    <= hit_n;
      hitm_q   <= hitm_n;
      snpv_q   <= snpv_n;
      cnt_q    <= cnt_n;
      owner_q  <= owner_n;
      result_q <= result_n;
      err_q    <= err_n;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign snp_valid  = snpv_q;
  assign snp_op     = op_q;
  assign snp_addr   = addr_q;
  assign dbg_state  = state_q;

`ifdef SNOOP_BUS_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state_q == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_txn     <= '0;
      stat_hitm    <= '0;
      stat_timeout <= '0;
    end else begin
      if (rsp_fire && stat_txn != '1) stat_txn <= stat_txn + 32'd1;
      if (rsp_fire && result_q == RES_HITM && stat_hitm != '1)
        stat_hitm <= stat_hitm + 32'd1;
      if ((snoop_to || wb_to) && stat_timeout != '1)
        stat_timeout <= stat_timeout + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_snoop_bus_responder
//
// Directed bench for snoop_bus_responder (NUM_AGENTS=4, SNOOP_TIMEOUT=8,
// WB_TIMEOUT=16). Inputs change 1 time unit after a rising edge and outputs
// are checked at that same point, away from the active edge. Cycle numbers
// in the comments count edges after the accepting edge T.
// ---------------------------------------------------------------------------
module tb_snoop_bus_responder;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [1:0]  req_id;
  logic [3:0]  snp_valid;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic [3:0]  snp_rsp_valid;
  logic [7:0]  snp_rsp;
  logic [3:0]  wb_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_result;
  logic        rsp_err;
  logic [1:0]  dbg_state;
`ifdef SNOOP_BUS_STATS_EN
  logic [31:0] stat_txn, stat_hitm, stat_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  snoop_bus_responder #(
    .NUM_AGENTS(4), .SNOOP_TIMEOUT(8), .WB_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_id(req_id),
    .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr),
    .snp_rsp_valid(snp_rsp_valid), .snp_rsp(snp_rsp), .wb_done(wb_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
`ifdef SNOOP_BUS_STATS_EN
    , .stat_txn(stat_txn), .stat_hitm(stat_hitm), .stat_timeout(stat_timeout)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] addr,
                           input logic [1:0] id);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_id = id;
    step();
    req_valid = 1'b0;
  endtask

  task automatic clear_snoop();
    snp_rsp_valid = '0; snp_rsp = '0; wb_done = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    checks++; if (snp_valid !== 4'b0000) begin failures++; $display("FAIL rst_snp_valid: got %b expected 0000", snp_valid); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_result !== 2'b11) begin failures++; $display("FAIL rst_rsp_result: got %b expected 11", rsp_result); end
    checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (snp_op !== 3'd0 || snp_addr !== 32'd0) begin failures++; $display("FAIL rst_snp_bus: got %0d/%h expected 0/0", snp_op, snp_addr); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  // READ id=0, all snooped agents NOHIT at T+1, plus a HITM strobe from the
  // requester itself that must be ignored.
  task automatic test_read_nohit();
    drive_req(OP_READ, 32'h0000_1000, 2'd0);
    checks++; if (snp_valid !== 4'b1110) begin failures++; $display("FAIL t1_snp_valid: got %b expected 1110", snp_valid); end
    checks++; if (snp_op !== OP_READ || snp_addr !== 32'h0000_1000) begin failures++; $display("FAIL t1_snp_bus: got %0d/%h expected 1/00001000", snp_op, snp_addr); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL t1_busy: got rsp_valid=%b req_ready=%b expected 0/0", rsp_valid, req_ready); end
    snp_rsp_valid = 4'b1111; snp_rsp = 8'hA9;
    step(); clear_snoop();
    checks++; if (snp_valid !== 4'b0000) begin failures++; $display("FAIL t1_snp_once: got %b expected 0000", snp_valid); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t1_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_result !== 2'b10 || rsp_err !== 1'b0) begin failures++; $display("FAIL t1_result: got %b err=%b expected 10 err=0", rsp_result, rsp_err); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL t1_hs_req_ready: got %b expected 0", req_ready); end
    handshake();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL t1_after_hs: got rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready); end
  endtask

  // RWIM id=2: 0/3 HIT at T+1, agent1 HITM at T+3, wb_done[1] at T+6.
  task automatic test_rwim_writeback();
    drive_req(OP_RWIM, 32'h2000_0040, 2'd2);
    checks++; if (snp_valid !== 4'b1011) begin failures++; $display("FAIL t2_snp_valid: got %b expected 1011", snp_valid); end
    snp_rsp_valid = 4'b1001; snp_rsp = 8'h00;
    step(); clear_snoop();                             // T+2
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd1) begin failures++; $display("FAIL t2_still_snoop: got rsp_valid=%b state=%0d expected 0/1", rsp_valid, dbg_state); end
    step();                                            // T+3
    snp_rsp_valid = 4'b0010; snp_rsp = 8'h04;
    step(); clear_snoop();                             // T+4
    wb_done = 4'b1001;                                 // non-owner bits
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL t2_wait_wb: got state=%0d expected 2", dbg_state); end
    step(); wb_done = '0;                              // T+5
    step();                                            // T+6
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t2_early_rsp: got %b expected 0", rsp_valid); end
    wb_done = 4'b0010;
    step(); wb_done = '0;                              // T+7
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t2_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_result !== 2'b01 || rsp_err !== 1'b0) begin failures++; $display("FAIL t2_result: got %b err=%b expected 01 err=0", rsp_result, rsp_err); end
    handshake();
  endtask

  // READ id=1, agent3 silent: agent0 HIT, agent2 NOHIT, duplicate HITM from
  // agent0 at T+4 ignored; snoop timeout gives rsp_valid at T+10.
  task automatic test_snoop_timeout();
    drive_req(OP_READ, 32'h0000_2080, 2'd1);
    checks++; if (snp_valid !== 4'b1101) begin failures++; $display("FAIL t3_snp_valid: got %b expected 1101", snp_valid); end
    snp_rsp_valid = 4'b0101; snp_rsp = 8'h20;
    step(); clear_snoop();                             // T+2
    step(); step();                                    // T+4
    snp_rsp_valid = 4'b0001; snp_rsp = 8'h01;
    step(); clear_snoop();                             // T+5
    step(); step(); step(); step();                    // T+9
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t3_early_rsp: got %b expected 0", rsp_valid); end
    step();                                            // T+10
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL t3_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_result !== 2'b00 || rsp_err !== 1'b1) begin failures++; $display("FAIL t3_result: got %b err=%b expected 00 err=1", rsp_result, rsp_err); end
    handshake();
  endtask

  // WRITE id=3: no snoop, NORESULT at T+1, held while rsp_ready low; a READ
  // waiting on req_valid is taken only after the handshake cycle.
  task automatic test_write_hold_back_to_back();
    drive_req(OP_WRITE, 32'hFFFF_FFC0, 2'd3);
    checks++; if (snp_valid !== 4'b0000) begin failures++; $display("FAIL t4_no_snoop: got %b expected 0000", snp_valid); end
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 2'b11 || rsp_err !== 1'b0) begin failures++; $display("FAIL t4_result: got v=%b %b err=%b expected v=1 11 err=0", rsp_valid, rsp_result, rsp_err); end
    checks++; if (snp_addr !== 32'hFFFF_FFC0) begin failures++; $display("FAIL t4_addr: got %h expected ffffffc0", snp_addr); end
    req_valid = 1'b1; req_op = OP_READ; req_addr = 32'h0000_3000; req_id = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 2'b11 || req_ready !== 1'b0 || snp_op !== OP_WRITE) begin
        failures++; $display("FAIL t4_hold%0d: got v=%b %b rdy=%b op=%0d expected v=1 11 rdy=0 op=2", i, rsp_valid, rsp_result, req_ready, snp_op);
      end
    end
    handshake();
    checks++; if (req_ready !== 1'b1 || snp_valid !== 4'b0000 || rsp_valid !== 1'b0) begin failures++; $display("FAIL t4_no_b2b: got rdy=%b snp=%b v=%b expected 1/0000/0", req_ready, snp_valid, rsp_valid); end
    step(); req_valid = 1'b0;
    checks++; if (snp_valid !== 4'b0111 || snp_op !== OP_READ || snp_addr !== 32'h0000_3000) begin failures++; $display("FAIL t4_next_req: got %b/%0d/%h expected 0111/1/00003000", snp_valid, snp_op, snp_addr); end
    snp_rsp_valid = 4'b0111; snp_rsp = 8'h2A;
    step(); clear_snoop();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 2'b10 || rsp_err !== 1'b0) begin failures++; $display("FAIL t4_next_result: got v=%b %b err=%b expected v=1 10 err=0", rsp_valid, rsp_result, rsp_err); end
    handshake();
  endtask

  // Illegal ops go straight to RESP with NORESULT and rsp_err.
  task automatic test_illegal_op();
    logic [2:0] bad_ops [2];
    bad_ops[0] = 3'd0; bad_ops[1] = 3'd7;
    for (int i = 0; i < 2; i++) begin
      drive_req(bad_ops[i], 32'h0000_0040, 2'd0);
      checks++; if (snp_valid !== 4'b0000 || rsp_valid !== 1'b1 || rsp_result !== 2'b11 || rsp_err !== 1'b1) begin
        failures++; $display("FAIL illegal_op%0d: got snp=%b v=%b %b err=%b expected 0000 v=1 11 err=1", bad_ops[i], snp_valid, rsp_valid, rsp_result, rsp_err);
      end
      handshake();
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear%0d: got %b expected 0", bad_ops[i], rsp_err); end
    end
  endtask

  // INVALIDATE id=1: agents 0 and 2 HITM, requester strobes too.
  task automatic test_invalidate_multi_hitm();
    drive_req(OP_INV, 32'h0000_4000, 2'd1);
    checks++; if (snp_valid !== 4'b1101) begin failures++; $display("FAIL t5_snp_valid: got %b expected 1101", snp_valid); end
    snp_rsp_valid = 4'b1111; snp_rsp = 8'h91;
    step(); clear_snoop();
    checks++; if (rsp_valid !== 1'b1 || dbg_state !== 2'd3) begin failures++; $display("FAIL t5_no_wb_wait: got v=%b state=%0d expected 1/3", rsp_valid, dbg_state); end
    checks++; if (rsp_result !== 2'b01 || rsp_err !== 1'b1) begin failures++; $display("FAIL t5_result: got %b err=%b expected 01 err=1", rsp_result, rsp_err); end
    handshake();
  endtask

  // READ id=0, agent2 HITM, owner never writes back: rsp at T+18 with error.
  task automatic test_wb_timeout();
    drive_req(OP_READ, 32'h0000_5000, 2'd0);
    snp_rsp_valid = 4'b1110; snp_rsp = 8'h98;
    step(); clear_snoop();                             // T+2
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL t7_wait_wb: got state=%0d expected 2", dbg_state); end
    wb_done = 4'b1011;                                 // everyone but the owner
    for (int i = 0; i < 15; i++) step();               // T+17
    wb_done = '0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL t7_early_rsp: got %b expected 0", rsp_valid); end
    step();                                            // T+18
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 2'b01 || rsp_err !== 1'b1) begin failures++; $display("FAIL t7_result: got v=%b %b err=%b expected v=1 01 err=1", rsp_valid, rsp_result, rsp_err); end
    handshake();
  endtask

  // Reset during WAIT_WB aborts; a following READ completes normally.
  task automatic test_reset_mid_txn();
    drive_req(OP_READ, 32'h0000_6000, 2'd0);
    snp_rsp_valid = 4'b1110; snp_rsp = 8'hA4;
    step(); clear_snoop();                             // T+2
    step();                                            // T+3
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL t6_in_wait_wb: got state=%0d expected 2", dbg_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || rsp_valid !== 1'b0 || rsp_result !== 2'b11 || req_ready !== 1'b1) begin
      failures++; $display("FAIL t6_abort: got state=%0d v=%b %b rdy=%b expected 0 v=0 11 rdy=1", dbg_state, rsp_valid, rsp_result, req_ready);
    end
    checks++; if (snp_op !== 3'd0 || snp_addr !== 32'd0) begin failures++; $display("FAIL t6_bus_clear: got %0d/%h expected 0/0", snp_op, snp_addr); end
    step();
    rst_n = 1'b1;
    step();
    drive_req(OP_READ, 32'h0000_7000, 2'd3);
    checks++; if (snp_valid !== 4'b0111) begin failures++; $display("FAIL t6_new_snp: got %b expected 0111", snp_valid); end
    snp_rsp_valid = 4'b0111; snp_rsp = 8'h0A;
    step(); clear_snoop();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 2'b00 || rsp_err !== 1'b0) begin failures++; $display("FAIL t6_new_result: got v=%b %b err=%b expected v=1 00 err=0", rsp_valid, rsp_result, rsp_err); end
    handshake();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_id = '0;
    snp_rsp_valid = '0; snp_rsp = '0; wb_done = '0; rsp_ready = 1'b0;
    test_reset();
    test_read_nohit();
    test_rwim_writeback();
    test_snoop_timeout();
    test_write_hold_back_to_back();
    test_illegal_op();
    test_invalidate_multi_hitm();
    test_wb_timeout();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
